// File: rtl/servant_obi_pkg.sv
// -----------------------------------------------------------------------------
// servant_obi_pkg
// Shared definitions for the OBI-to-Wishbone data-port responder:
//   - state_e     : transaction state (IDLE, BUS, RESP)
//   - DEF_*       : default parameter values for the responder
//   - cnt_width() : bit width needed by the watchdog to hold TIMEOUT-1
// -----------------------------------------------------------------------------
package servant_obi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int          DEF_MEM_BYTES = 8192;
   localparam int          DEF_TIMEOUT   = 15;
   localparam logic [31:0] DEF_TO_RDATA  = 32'h0000_0000;

   // Width of a counter that must hold values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/servant_obi_wdog.sv
// -----------------------------------------------------------------------------
// servant_obi_wdog
// Loadable down-counter that bounds how long a Wishbone cycle may wait for ack.
// Loaded with TIMEOUT-1 when a cycle starts; counts down once per active cycle
// and signals expiry on the last permitted cycle (TIMEOUT-th cycle of BUS).
//
// Ports:
//   clk_i     in  1  clock
//   rst_i     in  1  asynchronous active-high reset
//   load_i    in  1  start a new wait window
//   clr_i     in  1  return the counter to zero (cycle completed)
//   active_i  in  1  a Wishbone cycle is waiting this clock
//   expire_o  out 1  this is the last permitted waiting cycle
// -----------------------------------------------------------------------------
module servant_obi_wdog
   import servant_obi_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic clr_i,
   input  logic active_i,
   output logic expire_o
);

   localparam int            CW       = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   // Remaining-cycles counter: load at cycle start, decrement while waiting.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= {CW{1'b0}};
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (clr_i) begin
         cnt_q <= {CW{1'b0}};
      end else if (active_i && (cnt_q != {CW{1'b0}})) begin
         cnt_q <= cnt_q - CW'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   // Zero remaining while still waiting means the window has run out.
   assign expire_o = active_i && (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/servant_obi_wb_resp.sv
// -----------------------------------------------------------------------------
// servant_obi_wb_resp
// OBI-style data-port responder: each granted OBI request becomes one Wishbone
// classic cycle; exactly one rvalid pulse is returned per grant. One
// transaction outstanding at a time, bounded by a watchdog of TIMEOUT cycles.
//
// Optional feature macro: SERVANT_OBI_ERR_EN
//   defined  : adds o_obi_err; flags timeouts and addresses >= MEM_BYTES.
//              Out-of-range requests skip Wishbone and answer next cycle.
//   undefined: no o_obi_err; everything is forwarded, timeouts are silent.
//
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_obi_req / o_obi_gnt       OBI request handshake (gnt combinational)
//   i_obi_addr/we/be/wdata      OBI request attributes
//   o_obi_rvalid / o_obi_rdata  OBI response (registered)
//   o_obi_err                   response error (SERVANT_OBI_ERR_EN only)
//   o_wb_adr/dat/sel/we/cyc     Wishbone initiator outputs (registered)
//   i_wb_rdt / i_wb_ack         Wishbone read data and acknowledge
// -----------------------------------------------------------------------------
module servant_obi_wb_resp
   import servant_obi_pkg::*;
#(
   parameter int          MEM_BYTES = DEF_MEM_BYTES,
   parameter int          TIMEOUT   = DEF_TIMEOUT,
   parameter logic [31:0] TO_RDATA  = DEF_TO_RDATA
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_obi_req,
   output logic        o_obi_gnt,
   input  logic [31:0] i_obi_addr,
   input  logic        i_obi_we,
   input  logic [3:0]  i_obi_be,
   input  logic [31:0] i_obi_wdata,
   output logic        o_obi_rvalid,
   output logic [31:0] o_obi_rdata,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack
`ifdef SERVANT_OBI_ERR_EN
   ,
   output logic        o_obi_err
`endif
);

   state_e      state_q;
   logic [31:0] wb_adr_q;
   logic [31:0] wb_dat_q;
   logic [3:0]  wb_sel_q;
   logic        wb_we_q;
   logic        wb_cyc_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;

   logic        oor_s;
   logic        to_bus_s;
   logic        ack_s;
   logic        expire_s;

   // A new request can be taken when idle or while the previous one responds.
   assign o_obi_gnt = i_obi_req & ((state_q == IDLE) | (state_q == RESP));

`ifdef SERVANT_OBI_ERR_EN
   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
   logic err_q;
   assign oor_s     = ({1'b0, i_obi_addr} >= MEM_LIMIT);
   assign o_obi_err = err_q;
`else
   assign oor_s = 1'b0;
`endif

   assign to_bus_s = o_obi_gnt & ~oor_s;
   // Acks are only meaningful while a cycle is open.
   assign ack_s    = (state_q == BUS) & i_wb_ack;

   servant_obi_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .load_i   (to_bus_s),
      .clr_i    (ack_s),
      .active_i (state_q == BUS),
      .expire_o (expire_s)
   );

   // Transaction sequencer: capture request, run Wishbone cycle, respond.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         wb_adr_q <= 32'h0000_0000;
         wb_dat_q <= 32'h0000_0000;
         wb_sel_q <= 4'h0;
         wb_we_q  <= 1'b0;
         wb_cyc_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0000_0000;
`ifdef SERVANT_OBI_ERR_EN
         err_q    <= 1'b0;
`endif
      end else begin
         rvalid_q <= 1'b0;
`ifdef SERVANT_OBI_ERR_EN
         err_q    <= 1'b0;
`endif
         case (state_q)
            IDLE, RESP: begin
               if (to_bus_s) begin
                  wb_adr_q <= {i_obi_addr[31:2], 2'b00};
                  wb_dat_q <= i_obi_wdata;
                  wb_sel_q <= i_obi_be;
                  wb_we_q  <= i_obi_we;
                  wb_cyc_q <= 1'b1;
                  state_q  <= BUS;
               end
`ifdef SERVANT_OBI_ERR_EN
               else if (o_obi_gnt) begin
                  // Out of range: answer directly without touching the bus.
                  rvalid_q <= 1'b1;
                  rdata_q  <= TO_RDATA;
                  err_q    <= 1'b1;
                  state_q  <= RESP;
               end
`endif
               else begin
                  state_q <= IDLE;
               end
            end
            BUS: begin
               // Ack takes priority over a watchdog expiry in the same cycle.
               if (ack_s) begin
                  wb_cyc_q <= 1'b0;
                  rdata_q  <= wb_we_q ? 32'h0000_0000 : i_wb_rdt;
                  rvalid_q <= 1'b1;
                  state_q  <= RESP;
               end else if (expire_s) begin
                  wb_cyc_q <= 1'b0;
                  rdata_q  <= TO_RDATA;
                  rvalid_q <= 1'b1;
`ifdef SERVANT_OBI_ERR_EN
                  err_q    <= 1'b1;
`endif
                  state_q  <= RESP;
               end else begin
                  state_q <= BUS;
               end
            end
            default: begin
               wb_cyc_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign o_wb_adr     = wb_adr_q;
   assign o_wb_dat     = wb_dat_q;
   assign o_wb_sel     = wb_sel_q;
   assign o_wb_we      = wb_we_q;
   assign o_wb_cyc     = wb_cyc_q;
   assign o_obi_rvalid = rvalid_q;
   assign o_obi_rdata  = rdata_q;

endmodule
